// File: rtl/serial_magnitude_comparator.sv
// Serial magnitude comparator. It latches two WIDTH-bit operands and scans
// them MSD-first, DIGIT bits per cycle. The scan stops at the first digit
// that differs. It reports eq/gt/lt and one relation picked by mode.
// Optional build macro: SERIAL_CMP_SIGNED_EN compares the operands as two's
// complement values. It does this by flipping the sign bit of each operand
// when it is latched.
module serial_magnitude_comparator #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       mode,
    output logic             busy,
    output logic             done,
    output logic             result,
    output logic             eq,
    output logic             gt,
    output logic             lt
);

    localparam int NDIG = WIDTH / DIGIT;
    localparam int IDXW = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [IDXW-1:0] MSD = IDXW'(NDIG - 1);

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [2:0]       mode_q, mode_d;
    logic [IDXW-1:0]  idx_q, idx_d;
    logic             result_q, result_d;
    logic             eq_q, eq_d, gt_q, gt_d, lt_q, lt_d;

    logic [WIDTH-1:0] a_lat, b_lat;
    logic [DIGIT-1:0] dig_a, dig_b;

`ifdef SERIAL_CMP_SIGNED_EN
    // Flipping the sign bit turns two's-complement order into unsigned order.
    assign a_lat = {~a[WIDTH-1], a[WIDTH-2:0]};
    assign b_lat = {~b[WIDTH-1], b[WIDTH-2:0]};
`else
    assign a_lat = a;
    assign b_lat = b;
`endif

    assign dig_a = a_q[int'(idx_q)*DIGIT +: DIGIT];
    assign dig_b = b_q[int'(idx_q)*DIGIT +: DIGIT];

    // Relation select. Codes 110 and 111 are unused and give 0.
    function automatic logic sel_rel(input logic [2:0] m, input logic e,
                                     input logic g, input logic l);
        case (m)
            3'b000:  sel_rel = e;
            3'b001:  sel_rel = ~e;
            3'b010:  sel_rel = l;
            3'b011:  sel_rel = l | e;
            3'b100:  sel_rel = g;
            3'b101:  sel_rel = g | e;
            default: sel_rel = 1'b0;
        endcase
    endfunction

    // State and datapath registers. Reset clears everything, so a scan that
    // is in progress is dropped and produces no done pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            mode_q   <= '0;
            idx_q    <= '0;
            result_q <= 1'b0;
            eq_q     <= 1'b0;
            gt_q     <= 1'b0;
            lt_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            mode_q   <= mode_d;
            idx_q    <= idx_d;
            result_q <= result_d;
            eq_q     <= eq_d;
            gt_q     <= gt_d;
            lt_q     <= lt_d;
        end
    end

    // Next-state and datapath logic. Flags clear when a start is accepted and
    // are loaded when the FSM enters DONE. start is ignored outside IDLE.
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        mode_d   = mode_q;
        idx_d    = idx_q;
        result_d = result_q;
        eq_d     = eq_q;
        gt_d     = gt_q;
        lt_d     = lt_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d      = a_lat;
                    b_d      = b_lat;
                    mode_d   = mode;
                    idx_d    = MSD;
                    result_d = 1'b0;
                    eq_d     = 1'b0;
                    gt_d     = 1'b0;
                    lt_d     = 1'b0;
                    state_d  = SCAN;
                end
            end
            SCAN: begin
                if (dig_a != dig_b) begin
                    gt_d     = dig_a > dig_b;
                    lt_d     = dig_a < dig_b;
                    eq_d     = 1'b0;
                    result_d = sel_rel(mode_q, 1'b0, dig_a > dig_b, dig_a < dig_b);
                    state_d  = DONE;
                end else if (idx_q == '0) begin
                    eq_d     = 1'b1;
                    gt_d     = 1'b0;
                    lt_d     = 1'b0;
                    result_d = sel_rel(mode_q, 1'b1, 1'b0, 1'b0);
                    state_d  = DONE;
                end else begin
                    idx_d = idx_q - IDXW'(1);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign busy   = (state_q == SCAN);
    assign done   = (state_q == DONE);
    assign result = result_q;
    assign eq     = eq_q;
    assign gt     = gt_q;
    assign lt     = lt_q;

endmodule

// File: tb/tb_serial_magnitude_comparator.sv
// Directed bench for serial_magnitude_comparator.
// It exercises a WIDTH=8/DIGIT=1 instance and a WIDTH=8/DIGIT=4 instance.
module tb_serial_magnitude_comparator;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       s8 = 1'b0, s4 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0, a4 = '0, b4 = '0;
    logic [2:0] m8 = '0, m4 = '0;
    logic       busy8, done8, result8, eq8, gt8, lt8;
    logic       busy4, done4, result4, eq4, gt4, lt4;

    int ncmp = 0;
    int nfail = 0;

    serial_magnitude_comparator #(.WIDTH(8), .DIGIT(1)) dut8 (
        .clk(clk), .rst(rst), .start(s8), .a(a8), .b(b8), .mode(m8),
        .busy(busy8), .done(done8), .result(result8), .eq(eq8), .gt(gt8), .lt(lt8)
    );

    serial_magnitude_comparator #(.WIDTH(8), .DIGIT(4)) dut4 (
        .clk(clk), .rst(rst), .start(s4), .a(a4), .b(b4), .mode(m4),
        .busy(busy4), .done(done4), .result(result4), .eq(eq4), .gt(gt4), .lt(lt4)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // The caller must be in an IDLE cycle. Cycle 1 is the cycle right after
    // the edge that accepts start. The task returns during the done cycle.
    task automatic run(input string tag, input logic [7:0] av, input logic [7:0] bv,
                       input logic [2:0] mv, input int exp_cyc, input logic er,
                       input logic ee, input logic eg, input logic el);
        int cyc = 1;
        int bcnt = 0;
        int ovl = 0;
        logic got = 1'b0;
        a8 = av; b8 = bv; m8 = mv; s8 = 1'b1;
        tick();
        s8 = 1'b0;
        check({tag, ".clear"}, {28'd0, result8, eq8, gt8, lt8}, 32'd0);
        for (int i = 0; i < 40; i++) begin
            if (done8 && busy8) ovl++;
            if (done8) begin
                got = 1'b1;
                break;
            end
            if (busy8) bcnt++;
            tick();
            cyc++;
        end
        check({tag, ".done_seen"}, {31'd0, got}, 32'd1);
        check({tag, ".done_cyc"}, cyc, exp_cyc);
        check({tag, ".busy_cnt"}, bcnt, exp_cyc - 1);
        check({tag, ".overlap"}, ovl, 0);
        check({tag, ".flags"}, {28'd0, result8, eq8, gt8, lt8}, {28'd0, er, ee, eg, el});
    endtask

    initial begin
        int dcnt;
        // Reset state
        #12;
        check("rst.busy_done", {30'd0, busy8, done8}, 32'd0);
        check("rst.flags", {28'd0, result8, eq8, gt8, lt8}, 32'd0);
        rst = 1'b0;
        tick();

        run("ne_equal", 8'h5A, 8'h5A, 3'b001, 9, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        run("gt_bit3", 8'h0A, 8'h05, 3'b100, 6, 1'b1, 1'b0, 1'b1, 1'b0);
        tick();
`ifdef SERIAL_CMP_SIGNED_EN
        run("msb_gt", 8'h80, 8'h7F, 3'b100, 2, 1'b0, 1'b0, 1'b0, 1'b1);
`else
        run("msb_gt", 8'h80, 8'h7F, 3'b100, 2, 1'b1, 1'b0, 1'b1, 1'b0);
`endif
        // A start raised during DONE must be ignored.
        s8 = 1'b1; a8 = 8'h00; b8 = 8'h00; m8 = 3'b000;
        tick();
        check("done_ign.busy", {31'd0, busy8}, 32'd0);
        check("done_ign.eq", {31'd0, eq8}, 32'd0);
        // The start in the cycle after done is accepted.
        run("lt_b2b", 8'h10, 8'h20, 3'b010, 4, 1'b1, 1'b0, 1'b0, 1'b1);
        tick();
        run("mode110", 8'h7F, 8'h00, 3'b110, 3, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        run("ge_false", 8'h01, 8'h02, 3'b101, 8, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        run("mode111", 8'h3C, 8'h3C, 3'b111, 9, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        run("le_equal", 8'h00, 8'h00, 3'b011, 9, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        check("hold.flags", {28'd0, result8, eq8, gt8, lt8}, 32'h0000000C);
        // Reset asserted in IDLE clears the held flags without waiting for a clock.
        #2 rst = 1'b1;
        #1;
        check("async_rst.flags", {28'd0, result8, eq8, gt8, lt8}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        tick();

        // DIGIT=4. A start pulsed in cycle 1 must be ignored.
        a4 = 8'h12; b4 = 8'h13; m4 = 3'b011; s4 = 1'b1;
        tick();
        s4 = 1'b0;
        check("d4.c1_busy", {30'd0, busy4, done4}, 32'd2);
        a4 = 8'hFF; b4 = 8'h00; m4 = 3'b000; s4 = 1'b1;
        tick();
        s4 = 1'b0;
        check("d4.c2_busy", {30'd0, busy4, done4}, 32'd2);
        tick();
        check("d4.c3_done", {30'd0, busy4, done4}, 32'd1);
        check("d4.flags", {28'd0, result4, eq4, gt4, lt4}, 32'h00000009);
        tick();
        check("d4.idle_hold", {29'd0, done4, result4, lt4}, 32'd3);

        // Reset during scan cycle 3 stops the compare and gives no done pulse.
        a8 = 8'h00; b8 = 8'h00; m8 = 3'b000; s8 = 1'b1;
        tick();
        s8 = 1'b0;
        tick();
        tick();
        check("midrst.pre_busy", {31'd0, busy8}, 32'd1);
        #2 rst = 1'b1;
        #1;
        check("midrst.outs", {26'd0, busy8, done8, result8, eq8, gt8, lt8}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        dcnt = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (done8 || busy8) dcnt++;
        end
        check("midrst.no_done", dcnt, 0);
        run("post_rst_ge", 8'h01, 8'h00, 3'b101, 9, 1'b1, 1'b0, 1'b1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
